// File: rtl/dsec_host_link.sv
// dsec_host_link: host-side master for the DSEC top-level handshake.
// Feeds DSEC through a single hold register, sequences key loads and buffers results in a small FIFO.
module dsec_host_link #(
    parameter int DATA_W     = 64,
    parameter int KEY_WORDS  = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] src_data,
    input  logic              src_valid,
    output logic              src_ready,
    input  logic              cfg_start,
    input  logic [DATA_W-1:0] cfg_key,
    input  logic              cfg_valid,
    output logic              cfg_done,
    output logic [DATA_W-1:0] dsec_in_data,
    output logic              dsec_in_valid,
    output logic              dsec_key_config,
    input  logic              dsec_rdy,
    input  logic [DATA_W-1:0] dsec_out_data,
    input  logic              dsec_out_valid,
    output logic              dsec_out_rcvd,
    input  logic              dsec_error,
    input  logic [63:0]       dsec_error_code,
    output logic [DATA_W-1:0] snk_data,
    output logic              snk_valid,
    input  logic              snk_ready,
    output logic              fault,
    output logic [63:0]       fault_code,
    input  logic              fault_clr
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [63:0] TIMEOUT_CODE = 64'hFFFF_FFFF_FFFF_0001;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_KEYCFG, S_FAULT} state_t;

    state_t            state_q, state_d;
    logic              hold_full_q, hold_full_d;
    logic [DATA_W-1:0] hold_data_q, hold_data_d;
    logic              cfg_pend_q, cfg_pend_d;
    logic              armed_q, armed_d;
    logic [3:0]        key_cnt_q, key_cnt_d;
    logic [7:0]        to_cnt_q, to_cnt_d;
    logic              cfg_done_q, cfg_done_d;
    logic              out_rcvd_q, out_rcvd_d;
    logic              fault_q, fault_d;
    logic [63:0]       fault_code_q, fault_code_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] fifo_mem_q [FIFO_DEPTH];

    logic in_run, in_key, active, stall, timeout_hit, go_fault, key_last, clr_fault;
    logic run_ready, consume, load, push, pop, fifo_full, fifo_empty;

    assign in_run      = (state_q == S_RUN);
    assign in_key      = (state_q == S_KEYCFG);
    assign active      = in_run | in_key;
    assign clr_fault   = (state_q == S_FAULT) & fault_clr;
    assign stall       = in_run & hold_full_q & ~dsec_rdy;
    assign timeout_hit = stall & (to_cnt_q == 8'(TIMEOUT - 1));
    // A DSEC error outranks every other transition, including a final key beat.
    assign go_fault    = active & (dsec_error | timeout_hit);
    assign key_last    = in_key & cfg_valid & (key_cnt_q == 4'(KEY_WORDS - 1));
    assign fifo_full   = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty  = (count_q == '0);
    assign run_ready   = in_run & ~cfg_pend_q & (~hold_full_q | dsec_rdy);
    assign consume     = in_run & hold_full_q & dsec_rdy;
    assign load        = src_valid & run_ready & ~go_fault;
    assign push        = active & dsec_out_valid & armed_q & ~fifo_full & ~go_fault;
    assign pop         = ~fifo_empty & snk_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (en) state_d = S_RUN;
            S_RUN: begin
                if (go_fault)                       state_d = S_FAULT;
                else if (cfg_pend_q && !hold_full_q) state_d = S_KEYCFG;
            end
            S_KEYCFG: begin
                if (go_fault)      state_d = S_FAULT;
                else if (key_last) state_d = S_RUN;
            end
            S_FAULT:  if (fault_clr) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        src_ready       = 1'b0;
        dsec_in_valid   = 1'b0;
        dsec_key_config = 1'b0;
        dsec_in_data    = hold_data_q;
        case (state_q)
            S_RUN: begin
                src_ready     = run_ready;
                dsec_in_valid = hold_full_q;
            end
            S_KEYCFG: begin
                dsec_key_config = 1'b1;
                dsec_in_data    = cfg_key;
                dsec_in_valid   = cfg_valid;
            end
            default: ;
        endcase
        cfg_done      = cfg_done_q;
        dsec_out_rcvd = out_rcvd_q;
        snk_valid     = ~fifo_empty;
        snk_data      = fifo_empty ? '0 : fifo_mem_q[rd_ptr_q];
        fault         = fault_q;
        fault_code    = fault_code_q;
    end

    // Datapath next values
    always_comb begin
        hold_full_d = hold_full_q;
        hold_data_d = hold_data_q;
        if (clr_fault) begin
            hold_full_d = 1'b0;
            hold_data_d = '0;
        end else begin
            if (consume) hold_full_d = 1'b0;
            if (load) begin
                hold_full_d = 1'b1;
                hold_data_d = src_data;
            end
        end

        cfg_pend_d = cfg_pend_q;
        if (cfg_start && !cfg_pend_q && !in_key) cfg_pend_d = 1'b1;
        if ((key_last && !go_fault) || clr_fault) cfg_pend_d = 1'b0;

        key_cnt_d = '0;
        if (in_key) key_cnt_d = !cfg_valid ? key_cnt_q : (key_last ? 4'd0 : key_cnt_q + 4'd1);
        cfg_done_d = key_last & ~go_fault;

        to_cnt_d = stall ? to_cnt_q + 8'd1 : 8'd0;

        // One capture per out_valid high phase: disarm on capture, re-arm once out_valid drops.
        armed_d = armed_q;
        if (push)                armed_d = 1'b0;
        else if (!dsec_out_valid) armed_d = 1'b1;
        out_rcvd_d = push;

        fault_d      = fault_q;
        fault_code_d = fault_code_q;
        if (go_fault) begin
            fault_d      = 1'b1;
            fault_code_d = dsec_error ? dsec_error_code : TIMEOUT_CODE;
        end else if (clr_fault) begin
            fault_d = 1'b0;
        end

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_full_q  <= 1'b0;
            hold_data_q  <= '0;
            cfg_pend_q   <= 1'b0;
            armed_q      <= 1'b1;
            key_cnt_q    <= '0;
            to_cnt_q     <= '0;
            cfg_done_q   <= 1'b0;
            out_rcvd_q   <= 1'b0;
            fault_q      <= 1'b0;
            fault_code_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            hold_full_q  <= hold_full_d;
            hold_data_q  <= hold_data_d;
            cfg_pend_q   <= cfg_pend_d;
            armed_q      <= armed_d;
            key_cnt_q    <= key_cnt_d;
            to_cnt_q     <= to_cnt_d;
            cfg_done_q   <= cfg_done_d;
            out_rcvd_q   <= out_rcvd_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // FIFO storage needs no reset; the head is masked while empty.
    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= dsec_out_data;
    end
endmodule

// File: tb/tb_dsec_host_link.sv
// Directed bench for dsec_host_link: stream, capture/FIFO, key load, error, timeout and reset.
module tb_dsec_host_link;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, en, src_valid, cfg_start, cfg_valid, dsec_rdy;
    logic        dsec_out_valid, dsec_error, snk_ready, fault_clr;
    logic [63:0] src_data, cfg_key, dsec_out_data, dsec_error_code;
    logic        src_ready, cfg_done, dsec_in_valid, dsec_key_config, dsec_out_rcvd, snk_valid, fault;
    logic [63:0] dsec_in_data, snk_data, fault_code;

    int n_total = 0;
    int n_pass  = 0;

    dsec_host_link dut (
        .clk(clk), .rst(rst), .en(en),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .cfg_start(cfg_start), .cfg_key(cfg_key), .cfg_valid(cfg_valid), .cfg_done(cfg_done),
        .dsec_in_data(dsec_in_data), .dsec_in_valid(dsec_in_valid), .dsec_key_config(dsec_key_config),
        .dsec_rdy(dsec_rdy), .dsec_out_data(dsec_out_data), .dsec_out_valid(dsec_out_valid),
        .dsec_out_rcvd(dsec_out_rcvd), .dsec_error(dsec_error), .dsec_error_code(dsec_error_code),
        .snk_data(snk_data), .snk_valid(snk_valid), .snk_ready(snk_ready),
        .fault(fault), .fault_code(fault_code), .fault_clr(fault_clr)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
            $display("ok   %s = %h", tag, got);
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        #2;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b0; src_valid = 1'b0; cfg_start = 1'b0; cfg_valid = 1'b0;
        dsec_rdy = 1'b0; dsec_out_valid = 1'b0; dsec_error = 1'b0; snk_ready = 1'b0;
        fault_clr = 1'b0; src_data = '0; cfg_key = '0; dsec_out_data = '0; dsec_error_code = '0;
        cyc(); cyc();
        rst = 1'b0; look();
        check("rst_src_ready", src_ready, 0);
        check("rst_cfg_done", cfg_done, 0);
        check("rst_in_valid", dsec_in_valid, 0);
        check("rst_key_cfg", dsec_key_config, 0);
        check("rst_in_data", dsec_in_data, 0);
        check("rst_out_rcvd", dsec_out_rcvd, 0);
        check("rst_snk_valid", snk_valid, 0);
        check("rst_snk_data", snk_data, 0);
        check("rst_fault", fault, 0);
        check("rst_fault_code", fault_code, 0);

        // Stream three words with dsec_rdy held high
        en = 1'b1; dsec_rdy = 1'b1; look();
        check("idle_src_ready", src_ready, 0);
        cyc(); src_valid = 1'b1; src_data = 64'h11; look();
        check("st1_src_ready", src_ready, 1);
        check("st1_in_valid", dsec_in_valid, 0);
        cyc(); src_data = 64'h22; look();
        check("st2_in_valid", dsec_in_valid, 1);
        check("st2_in_data", dsec_in_data, 64'h11);
        check("st2_src_ready", src_ready, 1);
        cyc(); src_data = 64'h33; look();
        check("st3_in_data", dsec_in_data, 64'h22);
        check("st3_src_ready", src_ready, 1);
        cyc(); src_valid = 1'b0; look();
        check("st4_in_valid", dsec_in_valid, 1);
        check("st4_in_data", dsec_in_data, 64'h33);
        cyc(); look();
        check("st5_in_valid", dsec_in_valid, 0);

        // out_valid held 5 cycles: exactly one capture
        cyc(); dsec_out_valid = 1'b1; dsec_out_data = 64'hAB; look();
        check("cap0_rcvd", dsec_out_rcvd, 0);
        check("cap0_snk_valid", snk_valid, 0);
        cyc(); look();
        check("cap1_rcvd", dsec_out_rcvd, 1);
        check("cap1_snk_valid", snk_valid, 1);
        check("cap1_snk_data", snk_data, 64'hAB);
        cyc(); look();
        check("cap2_rcvd", dsec_out_rcvd, 0);
        cyc(); cyc(); look();
        check("cap4_rcvd", dsec_out_rcvd, 0);
        cyc(); dsec_out_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            cyc(); dsec_out_valid = 1'b1; dsec_out_data = 64'hB0 + 64'(i);
            cyc(); dsec_out_valid = 1'b0; look();
            check("fill_rcvd", dsec_out_rcvd, 1);
        end
        // FIFO is full: the fourth result must stall until a pop
        cyc(); dsec_out_valid = 1'b1; dsec_out_data = 64'hB4;
        cyc(); look();
        check("full_rcvd_a", dsec_out_rcvd, 0);
        cyc(); look();
        check("full_rcvd_b", dsec_out_rcvd, 0);
        cyc(); snk_ready = 1'b1; look();
        check("full_head", snk_data, 64'hAB);
        check("full_rcvd_c", dsec_out_rcvd, 0);
        cyc(); snk_ready = 1'b0; look();
        check("pop_rcvd", dsec_out_rcvd, 0);
        check("pop_head", snk_data, 64'hB1);
        cyc(); look();
        check("late_rcvd", dsec_out_rcvd, 1);
        dsec_out_valid = 1'b0;
        cyc(); snk_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            look();
            check("drain_data", snk_data, 64'hB0 + 64'(i));
            cyc();
        end
        snk_ready = 1'b0; look();
        check("drain_empty", snk_valid, 0);

        // Key load requested while the hold register is full
        cyc(); dsec_rdy = 1'b0; src_valid = 1'b1; src_data = 64'h44; cfg_start = 1'b1; look();
        check("kc_src_ready", src_ready, 1);
        cyc(); src_valid = 1'b0; cfg_start = 1'b0; look();
        check("kc_pend_ready", src_ready, 0);
        check("kc_wait_key", dsec_key_config, 0);
        check("kc_wait_data", dsec_in_data, 64'h44);
        cyc(); look();
        check("kc_wait2_key", dsec_key_config, 0);
        cyc(); dsec_rdy = 1'b1; look();
        check("kc_drain_valid", dsec_in_valid, 1);
        cyc(); look();
        check("kc_empty_key", dsec_key_config, 0);
        check("kc_empty_valid", dsec_in_valid, 0);
        cyc(); cfg_valid = 1'b1; cfg_key = 64'hC0; look();
        check("kc_b1_key", dsec_key_config, 1);
        check("kc_b1_valid", dsec_in_valid, 1);
        check("kc_b1_data", dsec_in_data, 64'hC0);
        check("kc_b1_src_rdy", src_ready, 0);
        cyc(); cfg_key = 64'hC1; cfg_start = 1'b1; look();
        check("kc_b2_done", cfg_done, 0);
        cyc(); cfg_valid = 1'b0; cfg_start = 1'b0; look();
        check("kc_gap_key", dsec_key_config, 1);
        check("kc_gap_valid", dsec_in_valid, 0);
        cyc(); look();
        check("kc_gap2_key", dsec_key_config, 1);
        cyc(); cfg_valid = 1'b1; cfg_key = 64'hC2; look();
        check("kc_b3_done", cfg_done, 0);
        cyc(); cfg_key = 64'hC3; look();
        check("kc_b4_key", dsec_key_config, 1);
        check("kc_b4_done", cfg_done, 0);
        cyc(); cfg_valid = 1'b0; look();
        check("kc_done", cfg_done, 1);
        check("kc_run_key", dsec_key_config, 0);
        check("kc_run_src_rdy", src_ready, 1);
        cyc(); look();
        check("kc_done_once", cfg_done, 0);

        // DSEC error in the same cycle as a host beat
        cyc(); src_valid = 1'b1; src_data = 64'h55; dsec_error = 1'b1; dsec_error_code = 64'h42; look();
        check("err_src_ready", src_ready, 1);
        cyc(); src_valid = 1'b0; dsec_error = 1'b0; look();
        check("err_fault", fault, 1);
        check("err_code", fault_code, 64'h42);
        check("err_src_rdy", src_ready, 0);
        check("err_in_valid", dsec_in_valid, 0);
        cyc(); fault_clr = 1'b1;
        cyc(); fault_clr = 1'b0; look();
        check("clr_fault", fault, 0);
        check("clr_code_held", fault_code, 64'h42);
        check("clr_idle_rdy", src_ready, 0);
        cyc(); look();
        check("clr_run_rdy", src_ready, 1);
        check("clr_dropped", dsec_in_valid, 0);

        // 254 stalled cycles then rdy: no fault
        cyc(); src_valid = 1'b1; src_data = 64'h66; dsec_rdy = 1'b0;
        cyc(); src_valid = 1'b0;
        repeat (254) cyc();
        dsec_rdy = 1'b1; look();
        check("to254_fault", fault, 0);
        check("to254_valid", dsec_in_valid, 1);
        cyc(); src_valid = 1'b1; src_data = 64'h77; dsec_rdy = 1'b0; look();
        check("to254_after", fault, 0);
        // 255 stalled cycles: timeout fault
        cyc(); src_valid = 1'b0;
        repeat (254) cyc();
        look();
        check("to255_pre", fault, 0);
        cyc(); look();
        check("to255_fault", fault, 1);
        check("to255_code", fault_code, 64'hFFFF_FFFF_FFFF_0001);
        check("to255_valid", dsec_in_valid, 0);
        cyc(); fault_clr = 1'b1;
        cyc(); fault_clr = 1'b0; look();
        check("to_clr", fault, 0);
        cyc();

        // Reset after two of four key beats
        cyc(); cfg_start = 1'b1;
        cyc(); cfg_start = 1'b0; look();
        check("rk_pend_key", dsec_key_config, 0);
        cyc(); cfg_valid = 1'b1; cfg_key = 64'hD0; look();
        check("rk_key", dsec_key_config, 1);
        cyc(); cfg_key = 64'hD1;
        cyc(); rst = 1'b1; en = 1'b0;
        cyc(); rst = 1'b0; cfg_valid = 1'b0; look();
        check("rk_key_cfg", dsec_key_config, 0);
        check("rk_in_valid", dsec_in_valid, 0);
        check("rk_in_data", dsec_in_data, 0);
        check("rk_cfg_done", cfg_done, 0);
        check("rk_src_ready", src_ready, 0);
        check("rk_fault_code", fault_code, 0);
        check("rk_out_rcvd", dsec_out_rcvd, 0);
        check("rk_snk_valid", snk_valid, 0);
        cyc(); look();
        check("rk_no_done", cfg_done, 0);
        check("rk_idle_key", dsec_key_config, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/dsec_host_link.md
Name: dsec_host_link

Overview:
- Host-side master for the DSEC (data stream compression/encryption) top-level control handshake.
- Drives DSEC `in_valid`, key-load sequencing and `out_rcvd`; consumes DSEC `rdy`, `out_valid`, `error` and `error_code`.
- Buffers DSEC results in a small FIFO toward a ready/valid sink.
- Sits between the host DMA stream and the DSEC top level.

Parameters:
- DATA_W, 64, width of data/key words.
- KEY_WORDS, 4, key words streamed per key-config sequence (1..15).
- FIFO_DEPTH, 4, output FIFO entries (power of two, >=2).
- TIMEOUT, 255, max consecutive cycles a held input word may wait on `dsec_rdy` before fault (1..255).

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- en  in  1  level; leave IDLE and start streaming
- src_data  in  DATA_W  host input word
- src_valid  in  1  host word valid
- src_ready  out  1  host word accepted when src_valid&src_ready
- cfg_start  in  1  one-cycle pulse, request key load
- cfg_key  in  DATA_W  key word
- cfg_valid  in  1  key word valid (in KEYCFG)
- cfg_done  out  1  one-cycle pulse, key load complete
- dsec_in_data  out  DATA_W  word to DSEC
- dsec_in_valid  out  1  drives DSEC in_valid
- dsec_key_config  out  1  drives DSEC key_config
- dsec_rdy  in  1  DSEC rdy
- dsec_out_data  in  DATA_W  DSEC result
- dsec_out_valid  in  1  DSEC out_valid (level, held until acknowledged)
- dsec_out_rcvd  out  1  drives DSEC out_rcvd
- dsec_error  in  1  DSEC error
- dsec_error_code  in  64  DSEC error_code
- snk_data  out  DATA_W  FIFO head
- snk_valid  out  1  FIFO non-empty
- snk_ready  in  1  sink pop
- fault  out  1  sticky fault flag
- fault_code  out  64  latched fault code
- fault_clr  in  1  leave FAULT

Behaviour:
- **Reset.** Synchronous, highest priority. State=IDLE. All outputs 0 (including `fault_code` and `dsec_in_data`). Hold register empty, FIFO empty, `cfg_pend`=0, `armed`=1, key/timeout counters 0.
- **States.** IDLE, RUN, KEYCFG, FAULT.
  - IDLE->RUN when `en`=1.
  - RUN->KEYCFG when `cfg_pend`=1 and hold register empty.
  - KEYCFG->RUN after KEY_WORDS `cfg_valid` beats.
  - Any non-IDLE state->FAULT on `dsec_error`=1 or timeout. Error has priority over every other transition in the same cycle.
  - FAULT->IDLE on `fault_clr`=1.
- **Input path (RUN).**
  - Single hold register.
  - `src_ready` = RUN & !`cfg_pend` & (hold empty | `dsec_rdy`).
  - A host beat loads the hold register on the next edge.
  - `dsec_in_valid` = hold full, combinationally, so there is 1 cycle latency src->DSEC.
  - A word is consumed on a cycle with `dsec_in_valid` & `dsec_rdy`. Same-cycle consume+load keeps the hold register full with the new word.
  - `dsec_in_valid` never depends on `dsec_rdy`.
- **Key config.**
  - A `cfg_start` pulse sets `cfg_pend`; additional pulses while pending or in KEYCFG are ignored.
  - In KEYCFG: `dsec_key_config`=1, `dsec_in_data`=`cfg_key`, `dsec_in_valid`=`cfg_valid`, `src_ready`=0.
  - A 4-bit counter counts `cfg_valid` beats. On beat KEY_WORDS: `cfg_done`=1 for the next cycle, `cfg_pend` clears, return to RUN.
- **Output capture (RUN and KEYCFG).**
  - Capture when `dsec_out_valid` & `armed` & FIFO not full (registered count).
  - Capture pushes `dsec_out_data`, clears `armed`, and asserts `dsec_out_rcvd` for exactly the following cycle.
  - `armed` re-sets on any cycle with `dsec_out_valid`=0. This gives exactly one capture per out_valid high phase.
  - When the FIFO is full, capture waits and `out_rcvd` is withheld, so DSEC stalls.
- **FIFO.**
  - Pointer width log2(FIFO_DEPTH) with wrap; count width log2(FIFO_DEPTH)+1.
  - `snk_data` = head entry (fall-through).
  - Pop on `snk_valid` & `snk_ready`.
  - Simultaneous push/pop leaves count unchanged.
  - Pop while empty has no effect; push while full cannot occur.
  - The sink may keep popping in FAULT.
- **Timeout.**
  - Counter increments while RUN & hold full & !`dsec_rdy`; clears otherwise.
  - Reaching TIMEOUT -> FAULT with `fault_code`=64'hFFFF_FFFF_FFFF_0001.
- **Fault.**
  - On `dsec_error`, latch `dsec_error_code` into `fault_code` and set `fault`=1.
  - In FAULT: `dsec_in_valid`, `dsec_key_config`, `src_ready`, `dsec_out_rcvd` = 0.
  - `fault_clr`: `fault` clears, `fault_code` is held, hold register and `cfg_pend` clear, FIFO kept.
  - `fault_clr` while `dsec_error` is still 1: the FAULT->IDLE transition and `fault` clearing are taken; error is then re-detected next cycle only after `en` moves to RUN.
- **Reset mid-operation.** Aborts any key load or transfer immediately; no `cfg_done` or `out_rcvd` pulse follows.

Test Plan:
- **Stream.** `en`=1; host sends 0x11, 0x22, 0x33 back-to-back with `dsec_rdy`=1 -> `dsec_in_valid` high cycles 2-4 carrying 0x11, 0x22, 0x33 in order, `src_ready` never low.
- **Capture/FIFO.** DSEC holds `out_valid` for 5 cycles with data 0xAB, `snk_ready`=0 -> exactly one push, `dsec_out_rcvd` one-cycle pulse, `snk_data`=0xAB. Then 4 more results with FIFO full -> 4th result not acknowledged until one pop.
- **Key config.** `cfg_start` while hold full -> KEYCFG entered only after drain. 4 `cfg_valid` beats (with a 2-cycle gap) -> `dsec_key_config`=1 throughout, `cfg_done` pulse once, RUN resumes.
- **Error.** `dsec_error`=1 with code 0x0000_0000_0000_0042 in the same cycle as a host beat -> FAULT, `fault`=1, `fault_code`=0x42, beat dropped. `fault_clr` -> IDLE, `fault`=0.
- **Timeout.** `dsec_rdy`=0 with hold full for TIMEOUT=255 cycles -> FAULT, `fault_code`=0xFFFF_FFFF_FFFF_0001. At 254 cycles followed by `rdy` -> no fault.
- **Reset.** Reset asserted mid-KEYCFG (2 of 4 beats) -> all outputs 0 next cycle, IDLE, no `cfg_done`.
